// File: rtl/lcd_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_rx
// Purpose  : Capture side of a parallel RGB LCD link. Registers the stream,
//            recovers active-pixel coordinates, measures line/frame timing
//            and declares lock after a run of conforming frames.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_rx #(
  parameter int LinePeriod  = 1056,
  parameter int H_ActivePix = 800,
  parameter int V_ActivePix = 480,
  parameter int LockFrames  = 2,
  parameter int TimeoutClks = 2112
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_de,
  input  logic [23:0] lcd_data,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        frame_start,
  output logic [10:0] line_period,
  output logic [10:0] h_active,
  output logic [9:0]  v_active,
  output logic        locked,
  output logic        timing_err
);

  localparam logic [10:0] CNT_MAX    = 11'h7ff;
  localparam logic [9:0]  LINES_MAX  = 10'h3ff;
  localparam logic [10:0] EXP_PERIOD = 11'(LinePeriod);
  localparam logic [10:0] EXP_HACT   = 11'(H_ActivePix);
  localparam logic [9:0]  EXP_VACT   = 10'(V_ActivePix);
  localparam logic [3:0]  EXP_GOOD   = 4'(LockFrames);
  // The line counter saturates at 2047, so a larger timeout is clipped there.
  localparam logic [10:0] TO_LIMIT   = (TimeoutClks > 2047) ? CNT_MAX : 11'(TimeoutClks);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic        hs_s1, vs_s1, de_s1;
  logic [23:0] data_s1;
  logic        hs_d, vs_d, de_d;
  logic        hs_fall, vs_fall, de_rise, de_fall;
  logic [10:0] cnt;
  logic [10:0] run;
  logic [9:0]  line_cnt;
  logic [9:0]  lines_total;
  logic        to_hit;
  logic        frame_ok;
  logic        lock_err;
  state_t      state, state_nx;
  logic [3:0]  good, good_nx;
  logic        locked_nx, err_nx;

  // Stage 1: register the raw stream plus one extra copy of the controls for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      hs_s1   <= 1'b1;
      vs_s1   <= 1'b1;
      de_s1   <= 1'b0;
      data_s1 <= '0;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      de_d    <= 1'b0;
    end else begin
      hs_s1   <= lcd_hsync;
      vs_s1   <= lcd_vsync;
      de_s1   <= lcd_de;
      data_s1 <= lcd_data;
      hs_d    <= hs_s1;
      vs_d    <= vs_s1;
      de_d    <= de_s1;
    end
  end

  assign hs_fall = hs_d & ~hs_s1;
  assign vs_fall = vs_d & ~vs_s1;
  assign de_rise = de_s1 & ~de_d;
  assign de_fall = ~de_s1 & de_d;

  // Lines in the current frame including one that ends in this very cycle.
  assign lines_total = (de_fall && line_cnt != LINES_MAX) ? line_cnt + 10'd1 : line_cnt;
  // Fires once, on the cycle the counter steps onto the timeout value.
  assign to_hit   = !hs_fall && (cnt == TO_LIMIT - 11'd1);
  assign frame_ok = (line_period == EXP_PERIOD) && (h_active == EXP_HACT) && (lines_total == EXP_VACT);
  assign lock_err = (hs_fall && cnt != EXP_PERIOD) || (de_fall && run != EXP_HACT) ||
                    (vs_fall && lines_total != EXP_VACT);

  // Stage 2: pixel outputs and coordinates; coordinates hold while de is low.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= de_s1;
      pix_data    <= data_s1;
      frame_start <= vs_fall;
      if (de_s1) begin
        if (de_rise)               pix_x <= '0;
        else if (pix_x != CNT_MAX) pix_x <= pix_x + 11'd1;
      end
      if (vs_fall)      pix_y <= '0;
      else if (de_fall) pix_y <= pix_y + 10'd1;
    end
  end

  // Timing measurement: hsync period, de run length and active lines per frame.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt         <= '0;
      line_period <= '0;
      run         <= '0;
      h_active    <= '0;
      line_cnt    <= '0;
      v_active    <= '0;
    end else begin
      if (hs_fall) begin
        line_period <= cnt;
        cnt         <= 11'd1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 11'd1;
      end
      if (de_rise)                         run <= 11'd1;
      else if (de_s1 && run != CNT_MAX)    run <= run + 11'd1;
      if (de_fall) h_active <= run;
      if (vs_fall) begin
        v_active <= lines_total;
        line_cnt <= '0;
      end else begin
        line_cnt <= lines_total;
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= SEARCH;
      good       <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_nx;
      good       <= good_nx;
      locked     <= locked_nx;
      timing_err <= err_nx;
    end
  end

  // Lock FSM next state: timeout overrides everything, errors only matter once locked.
  always_comb begin
    state_nx  = state;
    good_nx   = good;
    locked_nx = locked;
    err_nx    = 1'b0;
    if (to_hit) begin
      state_nx  = SEARCH;
      good_nx   = '0;
      locked_nx = 1'b0;
      err_nx    = (state == LOCKED);
    end else begin
      case (state)
        SEARCH: begin
          locked_nx = 1'b0;
          if (vs_fall) begin
            state_nx = MEASURE;
            good_nx  = '0;
          end
        end
        MEASURE: begin
          if (vs_fall) begin
            if (frame_ok) begin
              good_nx = good + 4'd1;
              if (good + 4'd1 == EXP_GOOD) begin
                state_nx  = LOCKED;
                locked_nx = 1'b1;
              end
            end else begin
              good_nx = '0;
            end
          end
        end
        LOCKED: begin
          if (lock_err) begin
            err_nx    = 1'b1;
            locked_nx = 1'b0;
            good_nx   = '0;
            state_nx  = SEARCH;
          end
        end
        default: begin
          state_nx  = SEARCH;
          good_nx   = '0;
          locked_nx = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timing_rx
// Purpose  : Self-checking bench for lcd_timing_rx with reduced timing,
//            random pixel data and de placement, and a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_rx;

  localparam int LP  = 40;
  localparam int HA  = 16;
  localparam int VA  = 6;
  localparam int LF  = 2;
  localparam int TO  = 80;
  localparam int ALL = 100000;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_hsync = 1'b1;
  logic        lcd_vsync = 1'b1;
  logic        lcd_de = 1'b0;
  logic [23:0] lcd_data = '0;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_data;
  logic        frame_start;
  logic [10:0] line_period;
  logic [10:0] h_active;
  logic [9:0]  v_active;
  logic        locked;
  logic        timing_err;

  lcd_timing_rx #(
    .LinePeriod (LP),
    .H_ActivePix(HA),
    .V_ActivePix(VA),
    .LockFrames (LF),
    .TimeoutClks(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .lcd_hsync  (lcd_hsync),
    .lcd_vsync  (lcd_vsync),
    .lcd_de     (lcd_de),
    .lcd_data   (lcd_data),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .frame_start(frame_start),
    .line_period(line_period),
    .h_active   (h_active),
    .v_active   (v_active),
    .locked     (locked),
    .timing_err (timing_err)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sample waiting in the input register, the one before it,
  // unbounded elapsed counts, and the expected output values.
  bit          p_hs, p_vs, p_de, s_hs, s_vs, s_de;
  logic [23:0] s_data;
  int          m_since_hs, m_de_len, m_lines, m_mode, m_good;
  bit          e_valid, e_fs, e_locked, e_err;
  int          e_x, e_y, e_lp, e_ha, e_va;
  logic [23:0] e_data;

  // Observation tallies, cleared by each scenario.
  int    n_err_obs, n_err_exp, n_valid, n_fs, max_x, max_y, diff_cycles;
  string last_diff;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    p_hs = 1; p_vs = 1; p_de = 0; s_hs = 1; s_vs = 1; s_de = 0; s_data = '0;
    m_since_hs = 0; m_de_len = 0; m_lines = 0; m_mode = 0; m_good = 0;
    e_valid = 0; e_fs = 0; e_locked = 0; e_err = 0;
    e_x = 0; e_y = 0; e_lp = 0; e_ha = 0; e_va = 0; e_data = '0;
  endtask

  // One sample moves from the input register into the output stage.
  task automatic model_step();
    bit hsf, vsf, drise, dfall, tmo, bad;
    int period, lines_tot;
    hsf       = p_hs && !s_hs;
    vsf       = p_vs && !s_vs;
    drise     = s_de && !p_de;
    dfall     = !s_de && p_de;
    period    = sat(m_since_hs, 2047);
    lines_tot = sat(m_lines + (dfall ? 1 : 0), 1023);
    tmo       = !hsf && (m_since_hs == TO - 1);
    e_err     = 0;
    if (tmo) begin
      e_err = (m_mode == 2); m_mode = 0; m_good = 0; e_locked = 0;
    end else if (m_mode == 0) begin
      if (vsf) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (vsf) begin
        if (e_lp == LP && e_ha == HA && lines_tot == VA) begin
          m_good++;
          if (m_good >= LF) begin m_mode = 2; e_locked = 1; end
        end else begin
          m_good = 0;
        end
      end
    end else begin
      bad = (hsf && period != LP) || (dfall && sat(m_de_len, 2047) != HA) || (vsf && lines_tot != VA);
      if (bad) begin e_err = 1; e_locked = 0; m_mode = 0; m_good = 0; end
    end
    if (hsf) begin e_lp = period; m_since_hs = 1; end
    else m_since_hs++;
    if (dfall) e_ha = sat(m_de_len, 2047);
    if (s_de) begin
      m_de_len = drise ? 1 : m_de_len + 1;
      e_x = sat(m_de_len - 1, 2047);
    end
    e_valid = s_de;
    e_data  = s_data;
    if (vsf) e_y = 0;
    else if (dfall) e_y = (e_y + 1) % 1024;
    if (vsf) begin e_va = lines_tot; m_lines = 0; end
    else m_lines = lines_tot;
    e_fs = vsf;
    p_hs = s_hs; p_vs = s_vs; p_de = s_de;
  endtask

  task automatic clear_tallies();
    n_err_obs = 0; n_err_exp = 0; n_valid = 0; n_fs = 0;
    max_x = -1; max_y = -1; diff_cycles = 0; last_diff = "";
  endtask

  // Drive one clock of stimulus (called at a falling edge), then observe at the next falling edge.
  task automatic drive_cycle(input bit hs, input bit vs, input bit de, input logic [23:0] d, input bit rv);
    logic [80:0] got, exp;
    lcd_hsync = hs; lcd_vsync = vs; lcd_de = de; lcd_data = d; rst_n = rv;
    if (!rv) model_reset();
    else begin
      model_step();
      s_hs = hs; s_vs = vs; s_de = de; s_data = d;
    end
    @(negedge clk_i);
    if (timing_err === 1'b1) n_err_obs++;
    if (e_err) n_err_exp++;
    if (pix_valid === 1'b1) begin
      n_valid++;
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
    end
    if (frame_start === 1'b1) n_fs++;
    got = {pix_valid, pix_x, pix_y, pix_data, frame_start, line_period, h_active, v_active, locked, timing_err};
    exp = {e_valid, 11'(e_x), 10'(e_y), e_data, e_fs, 11'(e_lp), 11'(e_ha), 10'(e_va), e_locked, e_err};
    if (got !== exp) begin
      diff_cycles++;
      last_diff = $sformatf("t=%0t got v%0b x%0d y%0d fs%0b lp%0d ha%0d va%0d lk%0b er%0b exp v%0b x%0d y%0d fs%0b lp%0d ha%0d va%0d lk%0b er%0b",
                            $time, pix_valid, pix_x, pix_y, frame_start, line_period, h_active, v_active, locked, timing_err,
                            e_valid, e_x, e_y, e_fs, e_lp, e_ha, e_va, e_locked, e_err);
    end
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 24'($urandom()), 1'b1);
  endtask

  // 10 lines of LP clocks: vsync low on lines 0-1, active lines from line 3,
  // hsync low for the first 4 clocks of each line, random de start.
  task automatic drive_frame(input int act, input int short_line, input int de_line, input int de_len,
                             input int skip, input int max_cyc);
    int ds;
    int cyc;
    ds  = int'($urandom_range(6, 20));
    cyc = 0;
    for (int l = 0; l < 10; l++) begin
      for (int c = 0; c < ((l == short_line) ? LP - 1 : LP); c++) begin
        if (cyc >= max_cyc) return;
        if (cyc >= skip)
          drive_cycle(c >= 4, l >= 2,
                      (l >= 3) && (l < 3 + act) && (c >= ds) && (c < ds + ((l == de_line) ? de_len : HA)),
                      24'($urandom()), 1'b1);
        cyc++;
      end
    end
  endtask

  task automatic good_frame();
    drive_frame(VA, -1, -1, HA, 0, ALL);
  endtask

  task automatic test_reset();
    clear_tallies();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 24'($urandom()), 1'b0);
    n_checks++;
    if ({pix_valid, frame_start, locked, timing_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000", {pix_valid, frame_start, locked, timing_err});
    end
    n_checks++;
    if ({pix_x, pix_y, pix_data} !== 45'd0) begin
      n_fail++; $display("FAIL reset_pixel: x=%0d y=%0d data=%h required 0", pix_x, pix_y, pix_data);
    end
    n_checks++;
    if ({line_period, h_active, v_active} !== 32'd0) begin
      n_fail++; $display("FAIL reset_meas: lp=%0d ha=%0d va=%0d required 0", line_period, h_active, v_active);
    end
  endtask

  task automatic test_lock();
    clear_tallies();
    drive_idle(20);
    good_frame();
    good_frame();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: locked=%b required 0", locked); end
    drive_frame(VA, -1, -1, HA, 0, 1);
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_at_vsfall: locked=%b required 0", locked); end
    drive_frame(VA, -1, -1, HA, 1, 2);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_one_after: locked=%b required 1", locked); end
    drive_frame(VA, -1, -1, HA, 2, ALL);
    n_checks++;
    if (line_period !== 11'(LP)) begin n_fail++; $display("FAIL lock_lp: got %0d required %0d", line_period, LP); end
    n_checks++;
    if (h_active !== 11'(HA)) begin n_fail++; $display("FAIL lock_ha: got %0d required %0d", h_active, HA); end
    n_checks++;
    if (v_active !== 10'(VA)) begin n_fail++; $display("FAIL lock_va: got %0d required %0d", v_active, VA); end
    n_checks++;
    if (n_err_obs !== 0) begin n_fail++; $display("FAIL lock_no_err: got %0d pulses required 0", n_err_obs); end
    n_checks++;
    if (diff_cycles !== 0) begin n_fail++; $display("FAIL lock_model: %0d cycles differ, last %s", diff_cycles, last_diff); end
  endtask

  task automatic test_pixel_path();
    clear_tallies();
    good_frame();
    n_checks++;
    if (n_valid !== HA * VA) begin n_fail++; $display("FAIL pix_count: got %0d required %0d", n_valid, HA * VA); end
    n_checks++;
    if (max_x !== HA - 1) begin n_fail++; $display("FAIL pix_max_x: got %0d required %0d", max_x, HA - 1); end
    n_checks++;
    if (max_y !== VA - 1) begin n_fail++; $display("FAIL pix_max_y: got %0d required %0d", max_y, VA - 1); end
    n_checks++;
    if (n_fs !== 1) begin n_fail++; $display("FAIL pix_frame_start: got %0d pulses required 1", n_fs); end
    n_checks++;
    if (diff_cycles !== 0) begin n_fail++; $display("FAIL pix_model: %0d cycles differ, last %s", diff_cycles, last_diff); end
  endtask

  task automatic test_short_line();
    clear_tallies();
    drive_frame(VA, 5, -1, HA, 0, ALL);
    n_checks++;
    if (n_err_obs !== 1) begin n_fail++; $display("FAIL short_err: got %0d pulses required 1", n_err_obs); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL short_unlock: locked=%b required 0", locked); end
    good_frame();
    good_frame();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL short_relock_early: locked=%b required 0", locked); end
    good_frame();
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL short_relock: locked=%b required 1", locked); end
    n_checks++;
    if (diff_cycles !== 0) begin n_fail++; $display("FAIL short_model: %0d cycles differ, last %s", diff_cycles, last_diff); end
  endtask

  task automatic test_short_de();
    clear_tallies();
    drive_frame(VA, -1, 4, HA - 1, 0, ALL);
    n_checks++;
    if (n_err_obs !== 1) begin n_fail++; $display("FAIL de_err: got %0d pulses required 1", n_err_obs); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL de_unlock: locked=%b required 0", locked); end
    drive_frame(VA - 1, -1, -1, HA, 0, ALL);
    good_frame();
    n_checks++;
    if (v_active !== 10'(VA - 1)) begin n_fail++; $display("FAIL de_va5: got %0d required %0d", v_active, VA - 1); end
    good_frame();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL de_good_cleared: locked=%b required 0", locked); end
    good_frame();
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL de_relock: locked=%b required 1", locked); end
    n_checks++;
    if (diff_cycles !== 0) begin n_fail++; $display("FAIL de_model: %0d cycles differ, last %s", diff_cycles, last_diff); end
  endtask

  task automatic test_timeout();
    clear_tallies();
    drive_idle(TO);
    n_checks++;
    if (n_err_obs !== 1) begin n_fail++; $display("FAIL to_err: got %0d pulses required 1", n_err_obs); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL to_unlock: locked=%b required 0", locked); end
    drive_idle(2100);
    n_checks++;
    if (n_err_obs !== 1) begin n_fail++; $display("FAIL to_no_repeat: got %0d pulses required 1", n_err_obs); end
    drive_frame(VA, -1, -1, HA, 0, 2);
    n_checks++;
    if (line_period !== 11'd2047) begin n_fail++; $display("FAIL to_saturate: got %0d required 2047", line_period); end
    drive_frame(VA, -1, -1, HA, 2, ALL);
    good_frame();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL to_search: locked=%b required 0", locked); end
    good_frame();
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL to_relock: locked=%b required 1", locked); end
    n_checks++;
    if (diff_cycles !== 0) begin n_fail++; $display("FAIL to_model: %0d cycles differ, last %s", diff_cycles, last_diff); end
  endtask

  task automatic test_random();
    int kind;
    clear_tallies();
    for (int f = 0; f < 8; f++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        1:       drive_frame(VA, int'($urandom_range(1, 8)), -1, HA, 0, ALL);
        2:       drive_frame(VA, -1, int'($urandom_range(3, 8)), int'($urandom_range(HA - 2, HA + 1)), 0, ALL);
        3:       drive_frame(int'($urandom_range(VA - 2, VA)), -1, -1, HA, 0, ALL);
        default: good_frame();
      endcase
    end
    n_checks++;
    if (n_err_obs !== n_err_exp) begin n_fail++; $display("FAIL rand_err_count: got %0d required %0d", n_err_obs, n_err_exp); end
    n_checks++;
    if (diff_cycles !== 0) begin n_fail++; $display("FAIL rand_model: %0d cycles differ, last %s", diff_cycles, last_diff); end
  endtask

  task automatic test_reset_midline();
    clear_tallies();
    for (int f = 0; f < 4; f++) good_frame();
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL rst_pre_lock: locked=%b required 1", locked); end
    drive_frame(VA, -1, -1, HA, 0, 5 * LP + 12);
    drive_cycle(1'b1, 1'b1, 1'b1, 24'($urandom()), 1'b0);
    n_checks++;
    if ({pix_valid, frame_start, locked, timing_err} !== 4'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b required 0000", {pix_valid, frame_start, locked, timing_err});
    end
    n_checks++;
    if ({pix_x, pix_y, pix_data, line_period, h_active, v_active} !== 77'd0) begin
      n_fail++; $display("FAIL rst_mid_values: x=%0d y=%0d lp=%0d ha=%0d va=%0d required 0", pix_x, pix_y, line_period, h_active, v_active);
    end
    drive_idle(10);
    n_checks++;
    if (n_err_obs !== 0) begin n_fail++; $display("FAIL rst_mid_no_err: got %0d pulses required 0", n_err_obs); end
    n_checks++;
    if (diff_cycles !== 0) begin n_fail++; $display("FAIL rst_mid_model: %0d cycles differ, last %s", diff_cycles, last_diff); end
  endtask

  initial begin
    model_reset();
    clear_tallies();
    @(negedge clk_i);
    test_reset();
    test_lock();
    test_pixel_path();
    test_short_line();
    test_short_de();
    test_timeout();
    test_random();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
